// File: rtl/latch_strobe_tx_pkg.sv
// latch_if_pkg: shared state type, default parameters and parameter legality check
package latch_if_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_BIT_CYCLES = 4;
  localparam int DEF_EN_START = 1;
  localparam int DEF_EN_LEN = 2;
  function automatic bit params_ok(int w, int bc, int es, int el);
    return w >= 1 && bc >= 3 && es >= 1 && el >= 1 && es + el <= bc - 1;
  endfunction
endpackage

// File: rtl/latch_strobe_tx_if.sv
// latch_strobe_tx_if: word handshake plus serial data/enable latch lines
interface latch_strobe_tx_if import latch_if_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic d_out;
  logic en_out;
  logic busy;
  logic done;
  modport master (output in_data, in_valid, input in_ready, d_out, en_out, busy, done);
  modport slave (input in_data, in_valid, output in_ready, d_out, en_out, busy, done);
endinterface

// File: rtl/latch_strobe_tx_bit_phase_timer.sv
// bit_phase_timer: cycle-within-bit counter producing bit_end and a registered enable window
module bit_phase_timer import latch_if_pkg::*; #(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int EN_START = DEF_EN_START,
  parameter int EN_LEN = DEF_EN_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic bit_end,
  output logic en_window
);
  localparam int CW = $clog2(BIT_CYCLES);
  logic [CW-1:0] cyc, cyc_nxt;
  assign bit_end = cyc == CW'(BIT_CYCLES - 1);
  assign cyc_nxt = (clear || bit_end) ? '0 : cyc + 1'b1;
  // window is decoded from the next count so en_window lines up with cyc as a flop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc <= '0;
      en_window <= 1'b0;
    end else if (clear || run) begin
      cyc <= cyc_nxt;
      en_window <= int'(cyc_nxt) >= EN_START && int'(cyc_nxt) < EN_START + EN_LEN;
    end else begin
      cyc <= '0;
      en_window <= 1'b0;
    end
endmodule

// File: rtl/latch_strobe_tx.sv
// latch_strobe_tx: serialises words MSB-first with a mid-bit latch-enable strobe
module latch_strobe_tx import latch_if_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int EN_START = DEF_EN_START,
  parameter int EN_LEN = DEF_EN_LEN
) (
  input logic clk,
  input logic rst_n,
  latch_strobe_tx_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  if (!params_ok(WIDTH, BIT_CYCLES, EN_START, EN_LEN)) begin : g_bad_params
    $error("latch_strobe_tx: illegal WIDTH/BIT_CYCLES/EN_START/EN_LEN");
  end
  state_t state;
  logic [WIDTH-1:0] sr, sr_shl;
  logic [BW-1:0] bit_cnt;
  logic accept, bit_end, en_window;
  assign accept = state == IDLE && bus.in_valid;
  assign sr_shl = sr << 1;
  assign bus.in_ready = state == IDLE;
  assign bus.en_out = en_window;
  bit_phase_timer #(.BIT_CYCLES(BIT_CYCLES), .EN_START(EN_START), .EN_LEN(EN_LEN)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(accept),
    .run(state == SHIFT),
    .bit_end(bit_end),
    .en_window(en_window)
  );
  // d_out only moves on a bit boundary, where the enable window is guaranteed closed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      bus.d_out <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        state <= SHIFT;
        sr <= bus.in_data;
        bit_cnt <= '0;
        bus.d_out <= bus.in_data[WIDTH-1];
        bus.busy <= 1'b1;
      end else if (state == SHIFT && bit_end) begin
        sr <= sr_shl;
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == BW'(WIDTH - 1)) begin
          state <= IDLE;
          bus.d_out <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else
          bus.d_out <= sr_shl[WIDTH-1];
      end
    end
endmodule

// File: tb/tb_latch_strobe_tx.sv
// tb_latch_strobe_tx: scoreboard bench driving two configurations into latch receiver models
module tb_latch_strobe_tx;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  latch_strobe_tx_if #(.WIDTH(8)) a ();
  latch_strobe_tx_if #(.WIDTH(8)) b ();
  latch_strobe_tx #(.WIDTH(8), .BIT_CYCLES(4), .EN_START(1), .EN_LEN(2)) dut (.clk(clk), .rst_n(rst_n), .bus(a));
  latch_strobe_tx #(.WIDTH(8), .BIT_CYCLES(6), .EN_START(2), .EN_LEN(3)) dut_v (.clk(clk), .rst_n(rst_n), .bus(b));

  logic lat_a, lat_b;
  always_latch if (a.en_out) lat_a <= a.d_out;
  always_latch if (b.en_out) lat_b <= b.d_out;

  logic [7:0] q0[$], q1[$];
  bit fr[2], dexp[2];
  int t[2];
  logic [7:0] cur[2], cap[2];
  logic pd[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference receiver model: timing derived from bit period and enable placement
  task automatic mon(input int c, input int bc, input int es, input int el, input logic rn,
                     input logic rdy, input logic vld, input logic bsy, input logic d,
                     input logic en, input logic dn, input logic lat);
    bit was;
    int ph, bi;
    if (!rn) begin
      fr[c] = 0;
      dexp[c] = 0;
      return;
    end
    was = fr[c];
    chk($sformatf("done%0d", c), dn, dexp[c]);
    dexp[c] = 0;
    chk($sformatf("in_ready%0d", c), rdy, !was);
    chk($sformatf("busy%0d", c), bsy, was);
    if (was) begin
      ph = t[c] % bc;
      bi = 7 - t[c] / bc;
      chk($sformatf("en_out%0d", c), en, ph >= es && ph < es + el);
      chk($sformatf("d_out%0d", c), d, cur[c][bi]);
      if (ph != 0) chk($sformatf("d_stable%0d", c), d, pd[c]);
      if (ph == bc - 1) begin
        chk($sformatf("latched_bit%0d", c), lat, cur[c][bi]);
        cap[c] = {cap[c][6:0], lat};
      end
      pd[c] = d;
      t[c]++;
      if (t[c] == 8 * bc) begin
        fr[c] = 0;
        dexp[c] = 1;
        chk($sformatf("word%0d", c), cap[c], cur[c]);
      end
    end else begin
      chk($sformatf("en_idle%0d", c), en, 0);
      chk($sformatf("d_idle%0d", c), d, 0);
      if (vld) begin
        fr[c] = 1;
        t[c] = 0;
        cap[c] = '0;
        if (c == 0 && q0.size() > 0) cur[c] = q0.pop_front();
        else if (c == 1 && q1.size() > 0) cur[c] = q1.pop_front();
        else chk($sformatf("unexpected_accept%0d", c), 1, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, 1, 2, rst_n, a.in_ready, a.in_valid, a.busy, a.d_out, a.en_out, a.done, lat_a);
    mon(1, 6, 2, 3, rst_n, b.in_ready, b.in_valid, b.busy, b.d_out, b.en_out, b.done, lat_b);
  end

  task automatic send(input int c, input logic [7:0] w, input bit drop);
    logic acc = 1'b0;
    int n = 0;
    if (c == 0) begin
      q0.push_back(w);
      a.in_data = w;
      a.in_valid = 1'b1;
    end else begin
      q1.push_back(w);
      b.in_data = w;
      b.in_valid = 1'b1;
    end
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = c == 0 ? a.in_ready : b.in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    if (drop) begin
      if (c == 0) a.in_valid = 1'b0;
      else b.in_valid = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals;
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_d_out", a.d_out, 0);
    chk("rst_en_out", a.en_out, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_in_ready_v", b.in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    a.in_valid = 1'b0;
    a.in_data = '0;
    b.in_valid = 1'b0;
    b.in_data = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    send(0, 8'hA5, 1);
    wait_cyc(40);
    send(0, 8'hFF, 0);
    send(0, 8'h00, 1);
    wait_cyc(40);
    send(0, 8'h81, 1);
    wait_cyc(10);
    send(0, 8'h3C, 1);
    wait_cyc(40);
    send(0, 8'hC3, 1);
    wait_cyc(13);
    chk("en_before_rst", a.en_out, 1);
    chk("busy_before_rst", a.busy, 1);
    rst_n = 1'b0;
    #1 chk_reset_vals();
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    send(0, 8'h5A, 1);
    wait_cyc(40);
    send(1, 8'h96, 1);
    wait_cyc(60);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
